// File: rtl/io_responder_pkg.sv
// Shared constants and helpers for the I/O responder: port addresses,
// LFSR parameters, the status register layout and small pure functions.
package io_responder_pkg;

  localparam int DATA_W = 8;

  // CPU-visible I/O port addresses
  localparam logic [7:0] IO_STATUS = 8'd0;
  localparam logic [7:0] IO_BTN    = 8'd1;
  localparam logic [7:0] IO_RAND   = 8'd2;
  localparam logic [7:0] IO_OUT    = 8'd3;

  // Random source: 8-bit Galois LFSR, maximal length (period 255)
  localparam logic [7:0] LFSR_MASK = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  // Layout of the byte returned by a read of IO_STATUS
  typedef struct packed {
    logic [3:0] count;
    logic       btn_any;
    logic       ovf;
    logic       full;
    logic       empty;
  } io_status_t;

  // One right-shift step of the Galois LFSR; a nonzero state never maps to 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_MASK : 8'h00);
  endfunction

  // Addresses that return data to the CPU
  function automatic logic is_readable(input logic [7:0] addr);
    return (addr == IO_STATUS) || (addr == IO_BTN) || (addr == IO_RAND);
  endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU-side control signals plus the output byte stream of the I/O responder.
// The shared data bus itself stays a plain inout port on the responder.
interface io_responder_if;
  import io_responder_pkg::*;

  logic [DATA_W-1:0] addr_bus;
  logic              c_ri;
  logic              c_ro;
  logic              mem_clk;
  logic              mem_io;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Responder side: takes CPU controls, produces the byte stream
  modport slave (
    input  addr_bus, c_ri, c_ro, mem_clk, mem_io, out_ready,
    output out_data, out_valid
  );

  // CPU/consumer side
  modport master (
    output addr_bus, c_ri, c_ro, mem_clk, mem_io, out_ready,
    input  out_data, out_valid
  );

endinterface

// File: rtl/io_responder_fifo.sv
// Byte FIFO feeding the display/LED driver. A push is still accepted when
// full if a pop happens on the same edge; head reads as 0 while empty.
module io_fifo
  import io_responder_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_pop_s;
  logic          do_push_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == FULL_CNT);
  assign count     = count_r;
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign head      = empty ? 8'h00 : mem_r[rd_ptr_r];

  // Storage array; contents are discarded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/io_responder.sv
// I/O-side responder on the CPU's shared data bus. Answers IN/OUT transfers
// (mem_io high) for four ports: status, sticky button events, an LFSR random
// source and a write FIFO drained over a valid/ready stream.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  io_responder_if.slave io,
  inout  wire  [7:0] bus,
  input  logic [3:0] btn_in
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          mem_q_r;
  logic          stb_s;
  logic          rd_hit_s;
  logic          rd_stb_s;
  logic          wr_stb_s;
  logic          ovf_set_s;
  logic          ovf_r;
  logic [7:0]    rd_buf_r;
  logic [7:0]    port_val_s;
  logic [7:0]    lfsr_r;
  logic [3:0]    btn_meta_r;
  logic [3:0]    btn_sync_r;
  logic [3:0]    btn_prev_r;
  logic [3:0]    btn_latch_r;
  logic [3:0]    btn_rise_s;
  logic [3:0]    btn_clr_s;
  logic          fifo_pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [7:0]    fifo_head_s;
  io_status_t    status_s;

  // One-cycle strobe on the first clk edge of each CPU memory phase
  assign stb_s     = io.mem_clk & ~mem_q_r;
  assign rd_hit_s  = io.mem_io & io.c_ro & is_readable(io.addr_bus);
  assign rd_stb_s  = stb_s & rd_hit_s;
  assign wr_stb_s  = stb_s & io.mem_io & io.c_ri & (io.addr_bus == IO_OUT);
  assign fifo_pop_s = ~fifo_empty_s & io.out_ready;
  // A write into a full FIFO is only lost if nothing leaves on the same edge
  assign ovf_set_s = wr_stb_s & fifo_full_s & ~fifo_pop_s;
  assign btn_rise_s = btn_sync_r & ~btn_prev_r;

  assign status_s.count   = 4'(fifo_count_s);
  assign status_s.btn_any = |btn_latch_r;
  assign status_s.ovf     = ovf_r;
  assign status_s.full    = fifo_full_s;
  assign status_s.empty   = fifo_empty_s;

  // Drive is released combinationally, including the instant reset asserts
  assign bus = (reset & rd_hit_s) ? rd_buf_r : 8'hzz;

  assign io.out_valid = ~fifo_empty_s;
  assign io.out_data  = fifo_head_s;

  io_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (wr_stb_s),
    .push_data (bus),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Select the value of the addressed readable port
  always_comb begin
    port_val_s = 8'h00;
    case (io.addr_bus)
      IO_STATUS: port_val_s = status_s;
      IO_BTN:    port_val_s = {4'h0, btn_latch_r};
      IO_RAND:   port_val_s = lfsr_r;
      default:   port_val_s = 8'h00;
    endcase
  end

  // Button bits cleared by a read are exactly those the read returns
  always_comb begin
    btn_clr_s = 4'h0;
    if (rd_stb_s && (io.addr_bus == IO_BTN)) begin
      btn_clr_s = btn_latch_r;
    end else begin
      btn_clr_s = 4'h0;
    end
  end

  // Memory-phase edge detector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mem_q_r <= 1'b0;
    else        mem_q_r <= io.mem_clk;
  end

  // Read buffer captured on the read strobe; drives bus for the rest of the read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        rd_buf_r <= 8'h00;
    else if (rd_stb_s) rd_buf_r <= port_val_s;
  end

  // Sticky overflow flag: set by a dropped write, cleared by a status read; set wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      ovf_r <= 1'b0;
    else if (ovf_set_s)                              ovf_r <= 1'b1;
    else if (rd_stb_s && (io.addr_bus == IO_STATUS)) ovf_r <= 1'b0;
  end

  // Two-flop synchroniser plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_r <= 4'h0;
      btn_sync_r <= 4'h0;
      btn_prev_r <= 4'h0;
    end else begin
      btn_meta_r <= btn_in;
      btn_sync_r <= btn_meta_r;
      btn_prev_r <= btn_sync_r;
    end
  end

  // Sticky button events; a new edge coinciding with a clearing read survives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_latch_r <= 4'h0;
    else        btn_latch_r <= (btn_latch_r & ~btn_clr_s) | btn_rise_s;
  end

  // Free-running random source
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_r <= LFSR_SEED;
    else        lfsr_r <= lfsr_next(lfsr_r);
  end

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder (DEPTH = 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_io_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_in;
  logic       tb_drv;
  logic [7:0] tb_bus;
  wire  [7:0] bus;
  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rd;

  io_responder_if ifc ();

  io_responder #(.DEPTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .io     (ifc.slave),
    .bus    (bus),
    .btn_in (btn_in)
  );

  assign bus = tb_drv ? tb_bus : 8'hzz;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // One CPU transfer: strobes and mem_clk raised at a falling edge, the strobe
  // edge follows, bus is sampled at the next falling edge. probe makes the bench
  // drive 0x00 so any drive from the DUT shows up as a nonzero value.
  task automatic xfer(input bit mio, input bit rdn, input bit wr, input bit probe,
                      input bit rdy, input logic [7:0] addr, input logic [7:0] wdata,
                      output logic [7:0] rdata);
    @(negedge clk);
    ifc.addr_bus  = addr;
    ifc.mem_io    = mio;
    ifc.c_ro      = rdn;
    ifc.c_ri      = wr;
    ifc.mem_clk   = 1'b1;
    ifc.out_ready = rdy;
    tb_drv        = wr | probe;
    tb_bus        = wr ? wdata : 8'h00;
    @(posedge clk);
    @(negedge clk);
    rdata         = bus;
    ifc.mem_clk   = 1'b0;
    ifc.c_ro      = 1'b0;
    ifc.c_ri      = 1'b0;
    ifc.mem_io    = 1'b0;
    ifc.out_ready = 1'b0;
    tb_drv        = 1'b0;
  endtask

  task automatic io_rd(input logic [7:0] addr, output logic [7:0] rdata);
    xfer(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, addr, 8'h00, rdata);
  endtask

  task automatic io_wr(input logic [7:0] data, input bit rdy);
    logic [7:0] dummy;
    xfer(1'b1, 1'b0, 1'b1, 1'b0, rdy, 8'd3, data, dummy);
  endtask

  // Drain with out_ready held high, expecting one byte per cycle from exp_q
  task automatic drain(input string name);
    logic [7:0] e;
    @(negedge clk);
    ifc.out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vec_cnt++;
      if (ifc.out_valid !== 1'b1 || ifc.out_data !== e) begin
        err_cnt++;
        $display("FAIL %s: valid=%b data=%h, required valid=1 data=%h", name, ifc.out_valid, ifc.out_data, e);
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (ifc.out_valid !== 1'b0 || ifc.out_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL %s_empty: valid=%b data=%h, required valid=0 data=00", name, ifc.out_valid, ifc.out_data);
    end
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (ifc.out_valid !== 1'b0 || ifc.out_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_out: valid=%b data=%h, required 0/00", ifc.out_valid, ifc.out_data);
    end
    reset = 1'b1;
  endtask

  task automatic test_rand;
    logic [7:0] exp_r [3];
    exp_r[0] = 8'hB8; exp_r[1] = 8'h2E; exp_r[2] = 8'hB3;
    for (int i = 0; i < 3; i++) begin
      io_rd(8'd2, rd);
      vec_cnt++;
      if (rd !== exp_r[i]) begin
        err_cnt++;
        $display("FAIL rand_%0d: got %h, required %h", i, rd, exp_r[i]);
      end
    end
    // bus released when idle, for a non-readable address, and for an unmapped one
    xfer(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'h00, rd);
    vec_cnt++;
    if (rd !== 8'h00) begin err_cnt++; $display("FAIL bus_idle: got %h, required 00", rd); end
    xfer(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 8'h00, rd);
    vec_cnt++;
    if (rd !== 8'h00) begin err_cnt++; $display("FAIL bus_rd_out_port: got %h, required 00", rd); end
    xfer(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd7, 8'h00, rd);
    vec_cnt++;
    if (rd !== 8'h00) begin err_cnt++; $display("FAIL bus_rd_unmapped: got %h, required 00", rd); end
    io_rd(8'd0, rd);
    vec_cnt++;
    if (rd !== 8'h01) begin err_cnt++; $display("FAIL status_idle: got %h, required 01", rd); end
  endtask

  task automatic test_fifo_basic;
    io_wr(8'h41, 1'b0);
    io_wr(8'h42, 1'b0);
    vec_cnt++;
    if (ifc.out_valid !== 1'b1 || ifc.out_data !== 8'h41) begin
      err_cnt++;
      $display("FAIL fifo_head: valid=%b data=%h, required 1/41", ifc.out_valid, ifc.out_data);
    end
    io_rd(8'd0, rd);
    vec_cnt++;
    if (rd !== 8'h20) begin err_cnt++; $display("FAIL status_cnt2: got %h, required 20", rd); end
    vec_cnt++;
    if (ifc.out_data !== 8'h41) begin err_cnt++; $display("FAIL fifo_hold: got %h, required 41", ifc.out_data); end
    exp_q = '{8'h41, 8'h42};
    drain("drain_basic");
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 9; i++) io_wr(8'h10 + 8'(i), 1'b0);
    io_rd(8'd0, rd);
    vec_cnt++;
    if (rd !== 8'h86) begin err_cnt++; $display("FAIL status_ovf: got %h, required 86", rd); end
    io_rd(8'd0, rd);
    vec_cnt++;
    if (rd !== 8'h82) begin err_cnt++; $display("FAIL status_ovf_clr: got %h, required 82", rd); end
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    drain("drain_ovf");
  endtask

  task automatic test_buttons;
    @(negedge clk); btn_in[2] = 1'b1;
    repeat (4) @(negedge clk);
    btn_in[2] = 1'b0;
    io_rd(8'd0, rd);
    vec_cnt++;
    if (rd !== 8'h09) begin err_cnt++; $display("FAIL status_btn: got %h, required 09", rd); end
    io_rd(8'd1, rd);
    vec_cnt++;
    if (rd !== 8'h04) begin err_cnt++; $display("FAIL btn_read: got %h, required 04", rd); end
    io_rd(8'd1, rd);
    vec_cnt++;
    if (rd !== 8'h00) begin err_cnt++; $display("FAIL btn_cleared: got %h, required 00", rd); end
    // latch bit 0, then make a second bit-0 edge land on the clearing read
    btn_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    btn_in[0] = 1'b1;
    @(negedge clk);
    io_rd(8'd1, rd);
    vec_cnt++;
    if (rd !== 8'h01) begin err_cnt++; $display("FAIL btn_coincide_rd: got %h, required 01", rd); end
    io_rd(8'd1, rd);
    vec_cnt++;
    if (rd !== 8'h01) begin err_cnt++; $display("FAIL btn_coincide_kept: got %h, required 01", rd); end
    io_rd(8'd1, rd);
    vec_cnt++;
    if (rd !== 8'h00) begin err_cnt++; $display("FAIL btn_coincide_clr: got %h, required 00", rd); end
    btn_in[0] = 1'b0;
  endtask

  task automatic test_mem_io_gate;
    @(negedge clk); btn_in[1] = 1'b1;
    repeat (4) @(negedge clk);
    btn_in[1] = 1'b0;
    io_rd(8'd2, rd);  // leaves a nonzero LFSR value in the read buffer
    xfer(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'h00, rd);
    vec_cnt++;
    if (rd !== 8'h00) begin err_cnt++; $display("FAIL memio0_bus: got %h, required 00", rd); end
    xfer(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'h55, rd);
    vec_cnt++;
    if (ifc.out_valid !== 1'b0) begin err_cnt++; $display("FAIL memio0_push: valid=%b, required 0", ifc.out_valid); end
    io_rd(8'd0, rd);
    vec_cnt++;
    if (rd !== 8'h09) begin err_cnt++; $display("FAIL memio0_status: got %h, required 09", rd); end
    io_rd(8'd1, rd);
    vec_cnt++;
    if (rd !== 8'h02) begin err_cnt++; $display("FAIL memio0_btn: got %h, required 02", rd); end
  endtask

  task automatic test_full_same_edge;
    for (int i = 0; i < 8; i++) io_wr(8'h21 + 8'(i), 1'b0);
    io_wr(8'h99, 1'b1);
    io_rd(8'd0, rd);
    vec_cnt++;
    if (rd !== 8'h82) begin err_cnt++; $display("FAIL full_push_pop: got %h, required 82", rd); end
    exp_q = '{8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h99};
    drain("drain_full_pp");
  endtask

  task automatic test_reset_mid;
    io_wr(8'h31, 1'b0);
    io_wr(8'h32, 1'b0);
    // read buffer holds 0x82; hold a status read open, then reset
    @(negedge clk);
    ifc.addr_bus = 8'd0; ifc.mem_io = 1'b1; ifc.c_ro = 1'b1;
    tb_drv = 1'b1; tb_bus = 8'h00;
    #2;
    reset = 1'b0;
    #1;
    vec_cnt++;
    if (bus !== 8'h00) begin err_cnt++; $display("FAIL reset_bus_release: got %h, required 00", bus); end
    vec_cnt++;
    if (ifc.out_valid !== 1'b0 || ifc.out_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_mid_out: valid=%b data=%h, required 0/00", ifc.out_valid, ifc.out_data);
    end
    ifc.mem_io = 1'b0; ifc.c_ro = 1'b0; tb_drv = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    io_rd(8'd2, rd);
    vec_cnt++;
    if (rd !== 8'hB8) begin err_cnt++; $display("FAIL reset_lfsr: got %h, required b8", rd); end
    io_rd(8'd0, rd);
    vec_cnt++;
    if (rd !== 8'h01) begin err_cnt++; $display("FAIL reset_status: got %h, required 01", rd); end
  endtask

  initial begin
    ifc.addr_bus = 8'h00; ifc.c_ri = 1'b0; ifc.c_ro = 1'b0;
    ifc.mem_clk = 1'b0; ifc.mem_io = 1'b0; ifc.out_ready = 1'b0;
    btn_in = 4'h0; tb_drv = 1'b0; tb_bus = 8'h00;
    test_reset;
    test_rand;
    test_fifo_basic;
    test_overflow;
    test_buttons;
    test_mem_io_gate;
    test_full_same_edge;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/io_responder.md
# io_responder

I/O-side responder for the CPU's shared data bus: it answers the transfers the CPU marks as I/O, i.e. IN/OUT with `mem_io` high. It exposes four ports:
- a status register;
- sticky button events;
- a free-running LFSR random source, used for food placement;
- a write FIFO that drains bytes to the display/LED driver over a valid/ready handshake.

It sits on `bus`/`addr_bus` next to the RAM and only responds when `mem_io` is high.

## Interface
- `DEPTH`, 8: output FIFO entries; power of two, 2..8.
- `clk` in 1: system clock, same clock that feeds the CPU.
- `reset` in 1: asynchronous, active-low; block held in reset while 0.
- `addr_bus` in 8: port address, driven by the CPU's MAR.
- `c_ri` in 1: CPU write strobe (data on `bus` goes into the addressed port).
- `c_ro` in 1: CPU read strobe (addressed port drives `bus`).
- `mem_clk` in 1: CPU memory phase, one `clk` period high every three.
- `mem_io` in 1: 1 = I/O transfer, 0 = memory; block is inert when 0.
- `bus` inout 8: shared data bus; Z unless this block is driving a read.
- `btn_in` in 4: raw asynchronous button levels.
- `out_data` out 8: FIFO head byte; 0 when `out_valid` = 0.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts the head byte this cycle.

## Operation
- Port map:
  - `IO_STATUS` = 0: read.
  - `IO_BTN` = 1: read.
  - `IO_RAND` = 2: read.
  - `IO_OUT` = 3: write.
  - Other addresses, reads of `IO_OUT`, and writes to ports 0-2 are ignored: no drive, no side effect.
- Strobe: `mem_q` is `mem_clk` registered. `stb = mem_clk & ~mem_q`. All CPU-side state changes happen only on `stb`.
- Write: on `stb` with `mem_io & c_ri` and `addr_bus == IO_OUT`:
  - not full: push `bus`;
  - full: drop the byte and set sticky `ovf`.
- Read: on `stb` with `mem_io & c_ro` and a readable address, load `rd_buf` with the port value. Side effects apply on the same edge.
- Bus drive: `bus = rd_buf` while `mem_io & c_ro` and the address is readable; otherwise Z (combinational enable).
- `IO_STATUS` value:
  - [0] FIFO empty;
  - [1] FIFO full;
  - [2] `ovf`;
  - [3] any `btn_latch` bit set;
  - [7:4] FIFO count.
  - Side effect: clears `ovf`, unless an overflow occurs on the same edge (set wins).
- `IO_BTN` value: {4'b0, `btn_latch`}.
  - Side effect: clears exactly the bits returned.
  - An edge arriving on the same `clk` edge stays set.
- Buttons: `btn_in` passes a 2-flop synchroniser; a rising edge of the synchronised level sets the matching `btn_latch` bit.
- `IO_RAND` value: current `lfsr`.
  - `lfsr` is an 8-bit Galois LFSR, mask 0xB8, advancing every `clk`.
  - Never reaches 0; period 255.
- FIFO: `out_valid = !empty`, `out_data = head`. Pop on `out_valid & out_ready`.
  - Push and pop on the same edge while full: both accepted; count unchanged; no `ovf`.
  - Push while empty: no pop that cycle.
  - Pointers wrap modulo `DEPTH`; count is 0..`DEPTH`.

## Timing
- Reset values:
  - `bus` Z; `out_valid` 0; `out_data` 0x00;
  - FIFO count 0; `ovf` 0; `btn_latch` 0;
  - synchronisers 0; `lfsr` 0x01; `rd_buf` 0x00; `mem_q` 0.
- Reset mid-operation: bus released immediately (asynchronous). FIFO contents discarded. Any pending strobe is lost.
- Read latency: `rd_buf` is valid one `clk` after `mem_clk` rises. This is the edge on which the CPU's internal clock captures `bus`.
- Write latency: the pushed byte appears on `out_data`/`out_valid` one `clk` after `stb` (registered count and pointers).
- Button latency: a `btn_in` rise is visible in `btn_latch` 3 `clk` later.
- Handshake:
  - `out_data` holds stable while `out_valid & !out_ready`.
  - The consumer may hold `out_ready` high permanently, giving 1 byte/cycle.

## Structure
- Port addresses `IO_STATUS`, `IO_BTN`, `IO_RAND`, `IO_OUT` and the LFSR mask go into the shared parameters include as defines, next to the opcode and state constants.
- One sub-module, `io_fifo`:
  - parameter `DEPTH`;
  - push/pop ports with data, full/empty/count;
  - same-edge push/pop when full is allowed.
- Everything else (strobe detect, decode, `rd_buf`, synchronisers, `btn_latch`, LFSR, tristate) stays in `io_responder`.

## Test plan
- Reset, then read `IO_RAND` at `clk` 1, 2, 3 after release → 0x01 advanced per mask: 0xB8, 0x5C, 0x2E; `bus` Z outside reads.
- Write 0x41, 0x42 to `IO_OUT` with `out_ready` = 0 → `out_valid` = 1 and `out_data` = 0x41. Raise `out_ready` → 0x42 next cycle, then `out_valid` = 0.
- Nine writes with `DEPTH` = 8 and `out_ready` = 0 → status reads 0x86 (count 8, full, ovf). A second status read → 0x82. Ninth byte absent on drain.
- Pulse `btn_in[2]` → `IO_BTN` reads 0x04 and status bit 3 = 1. A second read returns 0x00. An edge coinciding with the clearing read is kept.
- With `mem_io` = 0, assert `c_ro` at address 1 and `c_ri` at address 3 → `bus` stays Z and the FIFO is unchanged.
- Full FIFO with `out_ready` = 1 and a write on the same edge → count stays 8, `ovf` stays 0, the new byte is drained last.
